// File: rtl/in_service_register_seq.sv
// In-service register with two-pulse INTA vector sequencing, EOI/AEOI handling
// and a circular priority pointer for NUM_LEVELS interrupt levels.
module in_service_register_seq #(
   parameter int unsigned NUM_LEVELS = 8,
   parameter int unsigned IDX_W      = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  setValid,
   input  logic [IDX_W-1:0]      setIndex,
   input  logic                  intaPulse,
   input  logic [7:0]            vectorBase,
   input  logic                  aeoiMode,
   input  logic                  rotateOnAeoi,
   input  logic                  cmdValid,
   input  logic [2:0]            cmdType,
   input  logic [IDX_W-1:0]      cmdLevel,
   output logic [NUM_LEVELS-1:0] isrRegValue,
   output logic [IDX_W-1:0]      zeroLevelIndex,
   output logic [IDX_W-1:0]      highestIdx,
   output logic                  anyInService,
   output logic [7:0]            dataBuffer,
   output logic                  vectorValid,
   output logic [IDX_W-1:0]      resetedIndex,
   output logic                  clearValid
);

   localparam logic [IDX_W-1:0] LAST_LEVEL = IDX_W'(NUM_LEVELS - 1);

   localparam logic [2:0] CMD_EOI         = 3'd0;
   localparam logic [2:0] CMD_SPECIFIC    = 3'd1;
   localparam logic [2:0] CMD_ROT_EOI     = 3'd2;
   localparam logic [2:0] CMD_ROT_SPEC    = 3'd3;
   localparam logic [2:0] CMD_SET_PRIO    = 3'd4;

   typedef enum logic {IDLE, WAIT2} state_t;

   state_t                  state;
   logic [IDX_W-1:0]        curIdx;
   logic                    spurious;
   logic                    grantOk;
   logic [NUM_LEVELS-1:0]   setMask;
   logic [NUM_LEVELS-1:0]   clrMask;
   logic                    clrHit;
   logic [IDX_W-1:0]        clrIdx;
   logic                    ptrHit;
   logic [IDX_W-1:0]        ptrNext;
   logic                    unusedVecBits;

   function automatic logic [IDX_W-1:0] nextLevel(input logic [IDX_W-1:0] lvl);
      return (lvl == LAST_LEVEL) ? '0 : lvl + IDX_W'(1);
   endfunction

   function automatic logic inRange(input logic [IDX_W-1:0] lvl);
      return 32'(lvl) < NUM_LEVELS;
   endfunction

   function automatic logic [NUM_LEVELS-1:0] levelMask(input logic [IDX_W-1:0] lvl);
      return NUM_LEVELS'(1) << lvl;
   endfunction

   // Low vector bits are replaced by the level index.
   assign unusedVecBits = ^vectorBase[IDX_W-1:0];

   assign grantOk      = setValid && inRange(setIndex);
   assign anyInService = |isrRegValue;

   // Circular scan starting at the priority pointer; first set bit wins.
   always_comb begin : highestSearch
      logic [NUM_LEVELS-1:0] shifted;
      int unsigned           pos;
      logic                  found;
      highestIdx = '0;
      shifted    = '0;
      pos        = 0;
      found      = 1'b0;
      for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
         pos = 32'(zeroLevelIndex) + i;
         if (pos >= NUM_LEVELS) pos = pos - NUM_LEVELS;
         shifted = isrRegValue >> pos;
         if (!found && shifted[0]) begin
            highestIdx = IDX_W'(pos);
            found      = 1'b1;
         end
      end
   end

   // Set/clear masks and pointer update; command effects override AEOI ones.
   always_comb begin
      setMask = '0;
      clrMask = '0;
      clrHit  = 1'b0;
      clrIdx  = '0;
      ptrHit  = 1'b0;
      ptrNext = zeroLevelIndex;

      if (state == IDLE && intaPulse && grantOk) setMask = levelMask(setIndex);

      if (state == WAIT2 && intaPulse && aeoiMode && !spurious) begin
         clrMask = levelMask(curIdx);
         clrHit  = 1'b1;
         clrIdx  = curIdx;
         if (rotateOnAeoi) begin
            ptrHit  = 1'b1;
            ptrNext = nextLevel(curIdx);
         end
      end

      if (cmdValid) begin
         case (cmdType)
            CMD_EOI: if (anyInService) begin
               clrMask = clrMask | levelMask(highestIdx);
               clrHit  = 1'b1;
               clrIdx  = highestIdx;
            end
            CMD_SPECIFIC: if (inRange(cmdLevel)) begin
               clrMask = clrMask | levelMask(cmdLevel);
               clrHit  = 1'b1;
               clrIdx  = cmdLevel;
            end
            CMD_ROT_EOI: if (anyInService) begin
               clrMask = clrMask | levelMask(highestIdx);
               clrHit  = 1'b1;
               clrIdx  = highestIdx;
               ptrHit  = 1'b1;
               ptrNext = nextLevel(highestIdx);
            end
            CMD_ROT_SPEC: if (inRange(cmdLevel)) begin
               clrMask = clrMask | levelMask(cmdLevel);
               clrHit  = 1'b1;
               clrIdx  = cmdLevel;
               ptrHit  = 1'b1;
               ptrNext = nextLevel(cmdLevel);
            end
            CMD_SET_PRIO: if (inRange(cmdLevel)) begin
               ptrHit  = 1'b1;
               ptrNext = nextLevel(cmdLevel);
            end
            default: ;
         endcase
      end
   end

   // INTA sequencer and register state; a same-cycle set beats a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         isrRegValue    <= '0;
         zeroLevelIndex <= '0;
         dataBuffer     <= '0;
         vectorValid    <= 1'b0;
         resetedIndex   <= '0;
         clearValid     <= 1'b0;
         curIdx         <= '0;
         spurious       <= 1'b0;
      end else begin
         isrRegValue <= (isrRegValue & ~clrMask) | setMask;
         vectorValid <= 1'b0;
         clearValid  <= clrHit;
         if (clrHit) resetedIndex <= clrIdx;
         if (ptrHit) zeroLevelIndex <= ptrNext;
         case (state)
            IDLE: if (intaPulse) begin
               state <= WAIT2;
               if (grantOk) begin
                  curIdx   <= setIndex;
                  spurious <= 1'b0;
               end else begin
                  curIdx   <= LAST_LEVEL;
                  spurious <= 1'b1;
               end
            end
            WAIT2: if (intaPulse) begin
               dataBuffer  <= {vectorBase[7:IDX_W], curIdx};
               vectorValid <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_in_service_register_seq.sv
// Scoreboard bench: three instances (8, 4 and 6 levels) share strobes and are
// checked against a level-list reference model.
module tb_in_service_register_seq;

   logic       clk;
   logic       rst;
   logic       setValid;
   logic       intaPulse;
   logic [7:0] vb;
   logic       aeoi;
   logic       rot;
   logic       cmdValid;
   logic [2:0] cmdType;
   logic [2:0] siA, clA, siC, clC;
   logic [1:0] siB, clB;

   logic [7:0] isrA; logic [2:0] zA, hA, rA; logic anyA, vvA, cvA; logic [7:0] dA;
   logic [3:0] isrB; logic [1:0] zB, hB, rB; logic anyB, vvB, cvB; logic [7:0] dB;
   logic [5:0] isrC; logic [2:0] zC, hC, rC; logic anyC, vvC, cvC; logic [7:0] dC;

   in_service_register_seq #(.NUM_LEVELS(8), .IDX_W(3)) dutA (
      .clk(clk), .reset(rst), .setValid(setValid), .setIndex(siA), .intaPulse(intaPulse),
      .vectorBase(vb), .aeoiMode(aeoi), .rotateOnAeoi(rot), .cmdValid(cmdValid),
      .cmdType(cmdType), .cmdLevel(clA), .isrRegValue(isrA), .zeroLevelIndex(zA),
      .highestIdx(hA), .anyInService(anyA), .dataBuffer(dA), .vectorValid(vvA),
      .resetedIndex(rA), .clearValid(cvA));

   in_service_register_seq #(.NUM_LEVELS(4), .IDX_W(2)) dutB (
      .clk(clk), .reset(rst), .setValid(setValid), .setIndex(siB), .intaPulse(intaPulse),
      .vectorBase(vb), .aeoiMode(aeoi), .rotateOnAeoi(rot), .cmdValid(cmdValid),
      .cmdType(cmdType), .cmdLevel(clB), .isrRegValue(isrB), .zeroLevelIndex(zB),
      .highestIdx(hB), .anyInService(anyB), .dataBuffer(dB), .vectorValid(vvB),
      .resetedIndex(rB), .clearValid(cvB));

   in_service_register_seq #(.NUM_LEVELS(6), .IDX_W(3)) dutC (
      .clk(clk), .reset(rst), .setValid(setValid), .setIndex(siC), .intaPulse(intaPulse),
      .vectorBase(vb), .aeoiMode(aeoi), .rotateOnAeoi(rot), .cmdValid(cmdValid),
      .cmdType(cmdType), .cmdLevel(clC), .isrRegValue(isrC), .zeroLevelIndex(zC),
      .highestIdx(hC), .anyInService(anyC), .dataBuffer(dC), .vectorValid(vvC),
      .resetedIndex(rC), .clearValid(cvC));

   typedef struct {
      int isr; int zero; int hi; int any; int data; int vv; int cv; int rIdx;
   } obs_t;

   int checks = 0;
   int failures = 0;

   // Reference model state per unit.
   bit   svc [3][8];
   int   ptr [3];
   bit   wait2 [3];
   int   pend [3];
   bit   spur [3];
   int   dataE [3];
   int   rIdxE [3];
   obs_t snapQ [3][$];
   int   vecQ [3][$];
   int   clrQ [3][$];

   // Stimulus for the next cycle.
   bit sRst, sSv, sInta, sAeoi, sRot, sCv;
   int sCt, sVb;
   int sSi [3];
   int sCl [3];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int nLev(int u);
      case (u)
         0: return 8;
         1: return 4;
         default: return 6;
      endcase
   endfunction

   function automatic int wBits(int u);
      return (u == 1) ? 2 : 3;
   endfunction

   function automatic int highestModel(int u);
      int n = nLev(u);
      for (int k = 0; k < n; k++) begin
         if (svc[u][(ptr[u] + k) % n]) return (ptr[u] + k) % n;
      end
      return 0;
   endfunction

   function automatic int anyModel(int u);
      for (int l = 0; l < nLev(u); l++) if (svc[u][l]) return 1;
      return 0;
   endfunction

   task automatic check(string name, int u, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s unit%0d: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, u, act, act, exp, exp, $time);
      end
   endtask

   function automatic obs_t observe(int u);
      obs_t o;
      case (u)
         0: begin
            o.isr = int'(isrA); o.zero = int'(zA); o.hi = int'(hA); o.any = int'(anyA);
            o.data = int'(dA); o.vv = int'(vvA); o.cv = int'(cvA); o.rIdx = int'(rA);
         end
         1: begin
            o.isr = int'(isrB); o.zero = int'(zB); o.hi = int'(hB); o.any = int'(anyB);
            o.data = int'(dB); o.vv = int'(vvB); o.cv = int'(cvB); o.rIdx = int'(rB);
         end
         default: begin
            o.isr = int'(isrC); o.zero = int'(zC); o.hi = int'(hC); o.any = int'(anyC);
            o.data = int'(dC); o.vv = int'(vvC); o.cv = int'(cvC); o.rIdx = int'(rC);
         end
      endcase
      return o;
   endfunction

   // Predict the effect of the coming clock edge and queue expectations.
   task automatic modelStep();
      for (int u = 0; u < 3; u++) begin
         int   n = nLev(u);
         int   w = wBits(u);
         int   hi, setL, rep, np, vec;
         bit   clr [8];
         obs_t e;
         e.vv = 0;
         if (sRst) begin
            for (int l = 0; l < 8; l++) svc[u][l] = 0;
            ptr[u] = 0; wait2[u] = 0; dataE[u] = 0; rIdxE[u] = 0;
            pend[u] = 0; spur[u] = 0;
            e.cv = 0;
         end else begin
            hi = highestModel(u);
            setL = -1; rep = -1; np = -1;
            for (int l = 0; l < 8; l++) clr[l] = 0;
            if (sInta && !wait2[u]) begin
               if (sSv && sSi[u] < n) begin
                  setL = sSi[u]; pend[u] = sSi[u]; spur[u] = 0;
               end else begin
                  pend[u] = n - 1; spur[u] = 1;
               end
               wait2[u] = 1;
            end else if (sInta && wait2[u]) begin
               vec = ((sVb >> w) << w) + pend[u];
               dataE[u] = vec;
               e.vv = 1;
               vecQ[u].push_back(vec);
               if (sAeoi && !spur[u]) begin
                  clr[pend[u]] = 1; rep = pend[u];
                  if (sRot) np = (pend[u] + 1) % n;
               end
               wait2[u] = 0;
            end
            if (sCv) begin
               case (sCt)
                  0: if (anyModel(u) != 0) begin clr[hi] = 1; rep = hi; end
                  1: if (sCl[u] < n) begin clr[sCl[u]] = 1; rep = sCl[u]; end
                  2: if (anyModel(u) != 0) begin clr[hi] = 1; rep = hi; np = (hi + 1) % n; end
                  3: if (sCl[u] < n) begin
                        clr[sCl[u]] = 1; rep = sCl[u]; np = (sCl[u] + 1) % n;
                     end
                  4: if (sCl[u] < n) np = (sCl[u] + 1) % n;
                  default: ;
               endcase
            end
            for (int l = 0; l < n; l++) if (clr[l]) svc[u][l] = 0;
            if (setL >= 0) svc[u][setL] = 1;
            if (np >= 0) ptr[u] = np;
            e.cv = (rep >= 0) ? 1 : 0;
            if (rep >= 0) begin
               rIdxE[u] = rep;
               clrQ[u].push_back(rep);
            end
         end
         e.isr = 0;
         for (int l = 0; l < n; l++) if (svc[u][l]) e.isr += (1 << l);
         e.zero = ptr[u];
         e.hi = highestModel(u);
         e.any = anyModel(u);
         e.data = dataE[u];
         e.rIdx = rIdxE[u];
         snapQ[u].push_back(e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      rst = sRst; setValid = sSv; intaPulse = sInta; aeoi = sAeoi; rot = sRot;
      cmdValid = sCv; cmdType = 3'(sCt); vb = 8'(sVb);
      siA = 3'(sSi[0]); siB = 2'(sSi[1]); siC = 3'(sSi[2]);
      clA = 3'(sCl[0]); clB = 2'(sCl[1]); clC = 3'(sCl[2]);
      modelStep();
   endtask

   task automatic quiet();
      sRst = 0; sSv = 0; sInta = 0; sCv = 0; sCt = 0; sVb = 8'hE8;
   endtask

   task automatic setLv(int v, int c);
      sSi[0] = v; sSi[1] = v % 4; sSi[2] = v;
      sCl[0] = c; sCl[1] = c % 4; sCl[2] = c;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic grantVec(int lvl);
      quiet(); sInta = 1; sSv = 1; setLv(lvl, 0); step();
      quiet(); sInta = 1; step();
   endtask

   // Monitor: compare every cycle's outputs and drain pulse queues.
   initial begin
      obs_t e, a;
      int   q;
      forever begin
         @(posedge clk);
         #1;
         for (int u = 0; u < 3; u++) begin
            if (snapQ[u].size() > 0) begin
               e = snapQ[u].pop_front();
               a = observe(u);
               check("isrRegValue", u, a.isr, e.isr);
               check("zeroLevelIndex", u, a.zero, e.zero);
               check("highestIdx", u, a.hi, e.hi);
               check("anyInService", u, a.any, e.any);
               check("dataBuffer", u, a.data, e.data);
               check("vectorValid", u, a.vv, e.vv);
               check("clearValid", u, a.cv, e.cv);
               check("resetedIndex", u, a.rIdx, e.rIdx);
               if (a.vv != 0) begin
                  if (vecQ[u].size() == 0) check("vector queue occupancy", u, vecQ[u].size(), 1);
                  else begin
                     q = vecQ[u].pop_front();
                     check("vector byte", u, a.data, q);
                  end
               end
               if (a.cv != 0) begin
                  if (clrQ[u].size() == 0) check("clear queue occupancy", u, clrQ[u].size(), 1);
                  else begin
                     q = clrQ[u].pop_front();
                     check("cleared index", u, a.rIdx, q);
                  end
               end
            end
         end
      end
   end

   // Driver: directed scenarios then randomized traffic.
   initial begin
      sAeoi = 0; sRot = 0; setLv(0, 0);
      quiet(); sRst = 1; step(); step();
      quiet(); step(); settle();
      check("reset isr", 0, int'(isrA), 0);
      check("reset zero", 0, int'(zA), 0);
      check("reset data", 0, int'(dA), 0);

      // Basic two-pulse sequence and nonspecific EOI
      quiet(); sInta = 1; sSv = 1; setLv(3, 0); step(); settle();
      check("grant isr", 0, int'(isrA), 8'h08);
      quiet(); sInta = 1; step(); settle();
      check("vector EB", 0, int'(dA), 8'hEB);
      check("vector pulse", 0, int'(vvA), 1);
      quiet(); step(); settle();
      check("vector pulse end", 0, int'(vvA), 0);
      check("vector hold", 0, int'(dA), 8'hEB);
      quiet(); sCv = 1; sCt = 0; step(); settle();
      check("eoi isr", 0, int'(isrA), 0);
      check("eoi index", 0, int'(rA), 3);
      check("eoi pulse", 0, int'(cvA), 1);

      // AEOI with rotation
      sAeoi = 1; sRot = 1;
      grantVec(3); settle();
      check("aeoi isr", 0, int'(isrA), 0);
      check("aeoi rotate", 0, int'(zA), 4);
      check("aeoi index", 0, int'(rA), 3);
      sAeoi = 0; sRot = 0;

      // Circular search
      grantVec(0); grantVec(3); settle();
      check("isr 09", 0, int'(isrA), 8'h09);
      quiet(); sCv = 1; sCt = 4; setLv(0, 3); step(); settle();
      check("set priority", 0, int'(zA), 4);
      check("circular highest", 0, int'(hA), 0);
      quiet(); sCv = 1; sCt = 0; step(); settle();
      check("eoi wraps to bit0", 0, int'(isrA), 8'h08);
      quiet(); sCv = 1; sCt = 1; setLv(0, 3); step();

      // Spurious INTA with AEOI on
      sAeoi = 1;
      quiet(); sInta = 1; sSv = 0; step();
      quiet(); sInta = 1; step(); settle();
      check("spurious vector", 0, int'(dA), 8'hEF);
      check("spurious vector 4lv", 1, int'(dB), 8'hEB);
      check("spurious isr", 0, int'(isrA), 0);
      check("spurious no clear", 0, int'(cvA), 0);
      sAeoi = 0;

      // Boundary commands
      quiet(); sCv = 1; sCt = 0; step(); settle();
      check("empty eoi no pulse", 0, int'(cvA), 0);
      check("empty eoi ptr", 0, int'(zA), 4);
      quiet(); sCv = 1; sCt = 3; setLv(0, 7); step(); settle();
      check("rotate wrap", 0, int'(zA), 0);
      quiet(); sInta = 1; sSv = 1; sCv = 1; sCt = 1; setLv(5, 5); step(); settle();
      check("set beats clear", 0, int'(isrA), 8'h20);
      quiet(); sInta = 1; step();
      quiet(); sCv = 1; sCt = 1; setLv(0, 5); step();

      // Reset in WAIT2
      quiet(); sInta = 1; sSv = 1; setLv(2, 0); step();
      quiet(); sRst = 1; step(); settle();
      check("mid reset isr", 0, int'(isrA), 0);
      grantVec(2); settle();
      check("4lv vector EA", 1, int'(dB), 8'hEA);
      check("4lv vector pulse", 1, int'(vvB), 1);
      check("4lv isr", 1, int'(isrB), 4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         sRst  = ($urandom_range(0, 199) == 0);
         sInta = ($urandom_range(0, 2) == 0);
         sSv   = ($urandom_range(0, 3) != 0);
         sCv   = ($urandom_range(0, 3) == 0);
         sCt   = int'($urandom_range(0, 7));
         sVb   = int'($urandom_range(0, 255));
         sAeoi = ($urandom_range(0, 1) == 1);
         sRot  = ($urandom_range(0, 1) == 1);
         setLv(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         step();
      end

      quiet(); step(); step(); step(); settle();
      for (int u = 0; u < 3; u++) begin
         check("vector queue drained", u, vecQ[u].size(), 0);
         check("clear queue drained", u, clrQ[u].size(), 0);
         check("snapshot queue drained", u, snapQ[u].size(), 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/in_service_register_seq.md
Name: in_service_register_seq

Overview:
- Clocked, parametrised successor to the 8259A In-Service Register (ISR) for NUM_LEVELS interrupt levels.
- Tracks which levels are in service and runs the two-pulse INTA vector sequence as a state machine.
- Supports normal EOI, automatic EOI (AEOI), specific EOI, rotating EOI and set-priority commands, using a circular priority pointer.
- Sits between the priority resolver and the control logic / data bus buffer.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; legal range 2..8.
- IDX_W, 3, index width; must satisfy 2^IDX_W >= NUM_LEVELS.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- setValid  in  1  priority resolver has a granted level on setIndex.
- setIndex  in  IDX_W  granted level; sampled on the first INTA.
- intaPulse  in  1  one-cycle strobe per INTA pulse from control logic.
- vectorBase  in  8  ICW2 value; bits [7:IDX_W] form the vector's upper field.
- aeoiMode  in  1  ICW4 AEOI bit.
- rotateOnAeoi  in  1  rotate the priority pointer on each AEOI clear.
- cmdValid  in  1  one-cycle strobe: OCW2 command present.
- cmdType  in  3  0=nonspecific EOI, 1=specific EOI, 2=rotate nonspecific, 3=rotate specific, 4=set priority, others=no-op.
- cmdLevel  in  IDX_W  level for specific, rotate-specific and set-priority commands.
- isrRegValue  out  NUM_LEVELS  current ISR bits.
- zeroLevelIndex  out  IDX_W  current highest-priority level.
- highestIdx  out  IDX_W  highest-priority set ISR bit; 0 when the ISR is empty.
- anyInService  out  1  OR of all ISR bits.
- dataBuffer  out  8  vector byte.
- vectorValid  out  1  one-cycle pulse: dataBuffer holds the vector.
- resetedIndex  out  IDX_W  index of the last cleared bit.
- clearValid  out  1  one-cycle pulse: an ISR bit was cleared this cycle.

Behaviour:
- Reset values: isrRegValue=0, zeroLevelIndex=0, dataBuffer=0, vectorValid=0, resetedIndex=0, clearValid=0, state=IDLE. Reset overrides all inputs in the same cycle, including mid-sequence.
- State machine has two states: IDLE and WAIT2.
- IDLE, intaPulse=1, setValid=1:
  - Next edge sets isrRegValue[setIndex] and latches setIndex into curIdx.
  - State goes to WAIT2.
- IDLE, intaPulse=1, setValid=0 (spurious):
  - No ISR bit is set.
  - curIdx = NUM_LEVELS-1 and a spurious flag is set.
  - State goes to WAIT2.
- WAIT2, intaPulse=1:
  - Next edge drives dataBuffer = {vectorBase[7:IDX_W], curIdx}.
  - vectorValid=1 for exactly one cycle.
  - State returns to IDLE.
  - Latency: vector appears one cycle after the second INTA strobe.
- AEOI: if aeoiMode=1 and not spurious, the same edge as the vector also clears isrRegValue[curIdx].
  - resetedIndex=curIdx and clearValid=1.
  - If rotateOnAeoi=1, zeroLevelIndex=(curIdx+1) mod NUM_LEVELS.
- Holding values: dataBuffer holds its value after the pulse. intaPulse=0 holds the current state indefinitely.
- Highest-in-service search: highestIdx scans circularly from zeroLevelIndex upward, wrapping at NUM_LEVELS-1 to 0. The first set bit wins. Combinational from registered state.
- Commands are applied on the edge where cmdValid=1:
  - Nonspecific EOI (0): clears bit highestIdx.
  - Specific EOI (1): clears bit cmdLevel.
  - Rotate nonspecific (2): clears bit highestIdx and sets zeroLevelIndex=(highestIdx+1) mod NUM_LEVELS.
  - Rotate specific (3): clears bit cmdLevel and sets zeroLevelIndex=(cmdLevel+1) mod NUM_LEVELS.
  - Set priority (4): zeroLevelIndex=(cmdLevel+1) mod NUM_LEVELS; no bit is cleared.
- Every command clear sets resetedIndex and pulses clearValid.
- Nonspecific or rotate-nonspecific with an empty ISR: no change, no clearValid pulse, pointer unchanged.
- Specific EOI on a bit that is already 0: no ISR change, but resetedIndex updates and clearValid pulses.
- cmdLevel >= NUM_LEVELS: command ignored.
- Simultaneous events:
  - A set and a clear of different bits in the same cycle both apply.
  - A set and a clear of the same bit: the set wins.
  - AEOI clear and command clear in the same cycle: both apply, and resetedIndex reports the command clear.
  - AEOI rotate and command rotate in the same cycle: the command rotate wins for zeroLevelIndex.
- Out-of-range grant: setIndex >= NUM_LEVELS with setValid=1 is treated as spurious.

Test Plan:
1. Reset, vectorBase=8'hE8, aeoiMode=0, setIndex=3, two INTA strobes:
   - isrRegValue=8'h08.
   - dataBuffer=8'hEB with a one-cycle vectorValid.
   - Nonspecific EOI then gives isrRegValue=0, resetedIndex=3, clearValid pulse.
2. AEOI with rotation: aeoiMode=1, rotateOnAeoi=1, zeroLevelIndex=0, setIndex=3, two INTA strobes:
   - isrRegValue returns to 0 on the vector edge.
   - zeroLevelIndex=4 and resetedIndex=3.
3. Circular search: ISR=8'h09 (bits 0 and 3), set priority with cmdLevel=3 (zeroLevelIndex becomes 4):
   - highestIdx=0.
   - Nonspecific EOI clears bit 0, leaving 8'h08.
4. Spurious INTA: setValid=0, vectorBase=8'hE8, two INTA strobes:
   - dataBuffer=8'hEF (level 7).
   - ISR stays 0, no clearValid pulse, even with aeoiMode=1.
5. Boundary commands:
   - Nonspecific EOI on an empty ISR: no clearValid pulse, zeroLevelIndex unchanged.
   - Rotate specific with cmdLevel=7 gives zeroLevelIndex=0 (wrap).
   - Same-cycle set and specific EOI of bit 5: bit 5 ends set.
6. Reset mid-sequence and NUM_LEVELS=4 variant:
   - Assert reset in WAIT2: next cycle state=IDLE, ISR=0, and the next strobe behaves as a first INTA.
   - With NUM_LEVELS=4, IDX_W=2, vectorBase=8'hE8, setIndex=2: dataBuffer=8'hEA, and a spurious vector is 8'hEB.
